// File: rtl/l1_data_mem_responder.sv
// Data-memory responder for the L1 D-cache: queues cache requests, issues them to a
// 64-bit byte-enabled memory port and returns one in-order response beat per request.
module l1_data_mem_responder #(
    parameter int P_REQ_DEPTH = 4,
    parameter int P_OUT_DEPTH = 8
) (
    input  logic        iCLOCK,
    input  logic        iRESET,
    input  logic        iDATA_REQ,
    output logic        oDATA_LOCK,
    input  logic [1:0]  iDATA_ORDER,
    input  logic        iDATA_RW,
    input  logic [13:0] iDATA_TID,
    input  logic [1:0]  iDATA_MMUMOD,
    input  logic [31:0] iDATA_PDT,
    input  logic [31:0] iDATA_ADDR,
    input  logic [31:0] iDATA_DATA,
    output logic        oDATA_VALID,
    output logic [63:0] oDATA_DATA,
    output logic        oMEM_REQ,
    input  logic        iMEM_BUSY,
    output logic        oMEM_RW,
    output logic [28:0] oMEM_ADDR,
    output logic [7:0]  oMEM_BE,
    output logic [63:0] oMEM_DATA,
    input  logic        iMEM_VALID,
    input  logic [63:0] iMEM_DATA,
    output logic        oERR_UNEXPECTED
);
    localparam int RAW = $clog2(P_REQ_DEPTH);
    localparam int OAW = $clog2(P_OUT_DEPTH);
    localparam logic [RAW:0] REQ_FULL = (RAW+1)'(P_REQ_DEPTH);
    localparam logic [OAW:0] OUT_MAX  = (OAW+1)'(P_OUT_DEPTH);

    typedef struct packed {
        logic [1:0]  order;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    req_t        req_mem_q [P_REQ_DEPTH];
    req_t        req_mem_d [P_REQ_DEPTH];
    logic        ord_mem_q [P_OUT_DEPTH];
    logic        ord_mem_d [P_OUT_DEPTH];
    logic [63:0] rd_mem_q  [P_OUT_DEPTH];
    logic [63:0] rd_mem_d  [P_OUT_DEPTH];

    logic [RAW-1:0] req_wr_q, req_wr_d, req_rd_q, req_rd_d;
    logic [RAW:0]   req_cnt_q, req_cnt_d;
    logic [OAW-1:0] ord_wr_q, ord_wr_d, ord_rd_q, ord_rd_d;
    logic [OAW-1:0] rd_wr_q, rd_wr_d, rd_rd_q, rd_rd_d;
    logic [OAW:0]   rd_cnt_q, rd_cnt_d;
    logic [OAW:0]   out_cnt_q, out_cnt_d, out_rd_q, out_rd_d;
    logic           valid_q, valid_d, err_q, err_d;
    logic [63:0]    data_q, data_d;

    req_t     head;
    logic     accept, issue, pop_wr, pop_rd, rd_push;
    logic [2:0] lane;

    // Sideband fields travel with the request on the cache side but the address is physical.
    logic unused_sideband;
    assign unused_sideband = ^{iDATA_TID, iDATA_MMUMOD, iDATA_PDT};

    assign head       = req_mem_q[req_rd_q];
    assign lane       = head.addr[2:0];
    assign oDATA_LOCK = (req_cnt_q == REQ_FULL);
    assign accept     = iDATA_REQ && !oDATA_LOCK;
    assign oMEM_REQ   = (req_cnt_q != '0) && (out_cnt_q < OUT_MAX);
    assign issue      = oMEM_REQ && !iMEM_BUSY;
    assign pop_wr     = (out_cnt_q != '0) && !ord_mem_q[ord_rd_q];
    assign pop_rd     = (out_cnt_q != '0) && ord_mem_q[ord_rd_q] && (rd_cnt_q != '0);
    assign rd_push    = iMEM_VALID && (out_rd_q != '0);

    assign oMEM_RW         = head.rw;
    assign oMEM_ADDR       = head.addr[31:3];
    assign oDATA_VALID     = valid_q;
    assign oDATA_DATA      = data_q;
    assign oERR_UNEXPECTED = err_q;

    always_comb begin
        oMEM_BE   = 8'h0F << {lane[2], 2'b00};
        oMEM_DATA = {2{head.data}};
        case (head.order)
            2'd0: begin
                oMEM_BE   = 8'h01 << lane;
                oMEM_DATA = {8{head.data[7:0]}};
            end
            2'd1: begin
                oMEM_BE   = 8'h03 << {lane[2:1], 1'b0};
                oMEM_DATA = {4{head.data[15:0]}};
            end
            default: ;
        endcase
        if (head.rw) begin
            oMEM_BE = 8'hFF;
        end
    end

    always_comb begin
        req_mem_d = req_mem_q;
        ord_mem_d = ord_mem_q;
        rd_mem_d  = rd_mem_q;
        req_wr_d  = req_wr_q;
        req_rd_d  = req_rd_q;
        req_cnt_d = req_cnt_q;
        ord_wr_d  = ord_wr_q;
        ord_rd_d  = ord_rd_q;
        rd_wr_d   = rd_wr_q;
        rd_rd_d   = rd_rd_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        out_rd_d  = out_rd_q;
        valid_d   = pop_wr || pop_rd;
        data_d    = data_q;
        err_d     = err_q || (iMEM_VALID && (out_rd_q == '0));

        if (accept) begin
            req_mem_d[req_wr_q] = {iDATA_ORDER, iDATA_RW, iDATA_ADDR, iDATA_DATA};
            req_wr_d = req_wr_q + RAW'(1);
        end
        if (issue) begin
            req_rd_d = req_rd_q + RAW'(1);
            ord_mem_d[ord_wr_q] = head.rw;
            ord_wr_d = ord_wr_q + OAW'(1);
        end
        case ({accept, issue})
            2'b10:   req_cnt_d = req_cnt_q + (RAW+1)'(1);
            2'b01:   req_cnt_d = req_cnt_q - (RAW+1)'(1);
            default: ;
        endcase

        if (rd_push) begin
            rd_mem_d[rd_wr_q] = iMEM_DATA;
            rd_wr_d = rd_wr_q + OAW'(1);
        end
        if (pop_rd) begin
            rd_rd_d = rd_rd_q + OAW'(1);
        end
        case ({rd_push, pop_rd})
            2'b10:   rd_cnt_d = rd_cnt_q + (OAW+1)'(1);
            2'b01:   rd_cnt_d = rd_cnt_q - (OAW+1)'(1);
            default: ;
        endcase

        if (pop_wr || pop_rd) begin
            ord_rd_d = ord_rd_q + OAW'(1);
            data_d   = pop_rd ? rd_mem_q[rd_rd_q] : 64'd0;
        end
        case ({issue, pop_wr || pop_rd})
            2'b10:   out_cnt_d = out_cnt_q + (OAW+1)'(1);
            2'b01:   out_cnt_d = out_cnt_q - (OAW+1)'(1);
            default: ;
        endcase
        case ({issue && head.rw, pop_rd})
            2'b10:   out_rd_d = out_rd_q + (OAW+1)'(1);
            2'b01:   out_rd_d = out_rd_q - (OAW+1)'(1);
            default: ;
        endcase
    end

    // Storage arrays carry no reset; occupancy is tracked entirely by the counters.
    always_ff @(posedge iCLOCK) begin
        req_mem_q <= req_mem_d;
        ord_mem_q <= ord_mem_d;
        rd_mem_q  <= rd_mem_d;
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            req_wr_q  <= '0;
            req_rd_q  <= '0;
            req_cnt_q <= '0;
            ord_wr_q  <= '0;
            ord_rd_q  <= '0;
            rd_wr_q   <= '0;
            rd_rd_q   <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            out_rd_q  <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            req_wr_q  <= req_wr_d;
            req_rd_q  <= req_rd_d;
            req_cnt_q <= req_cnt_d;
            ord_wr_q  <= ord_wr_d;
            ord_rd_q  <= ord_rd_d;
            rd_wr_q   <= rd_wr_d;
            rd_rd_q   <= rd_rd_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
            out_rd_q  <= out_rd_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: doc/l1_data_mem_responder.md
Name: l1_data_mem_responder

Overview:
Memory-side responder for the L1 data cache's data-memory request port (REQ/LOCK/ORDER/RW/TID/MMUMOD/PDT/ADDR/DATA in, VALID/64-bit DATA out). It buffers incoming requests and issues them to a 64-bit backing memory port with byte enables. It returns exactly one in-order response beat per accepted request: read data for reads, a zero-data acknowledge for writes. This lets a single cache line fill (8 back-to-back reads) be absorbed without stalling the memory.

Parameters:
P_REQ_DEPTH, 4, request FIFO entries (power of 2, >=2)
P_OUT_DEPTH, 8, max issued-but-unanswered requests; also read-data FIFO depth (power of 2, >=8)

Ports:
iCLOCK  in  1  clock, all logic on rising edge
iRESET  in  1  synchronous, active-high reset
iDATA_REQ  in  1  request strobe from cache
oDATA_LOCK  out  1  1 = request FIFO full, iDATA_REQ not accepted this cycle
iDATA_ORDER  in  2  0=byte 1=half 2=word 3=treated as word
iDATA_RW  in  1  0=write 1=read
iDATA_TID  in  14  thread id, carried, unused
iDATA_MMUMOD  in  2  MMU mode, carried, unused (address is physical)
iDATA_PDT  in  32  page table base, carried, unused
iDATA_ADDR  in  32  byte address
iDATA_DATA  in  32  write data, right-aligned
oDATA_VALID  out  1  response beat
oDATA_DATA  out  64  read data (aligned 8B); 0 for write ack
oMEM_REQ  out  1  issue to backing memory
iMEM_BUSY  in  1  memory cannot accept this cycle
oMEM_RW  out  1  0=write 1=read
oMEM_ADDR  out  29  addr[31:3]
oMEM_BE  out  8  byte enables (writes); 8'hFF for reads
oMEM_DATA  out  64  lane-replicated write data
iMEM_VALID  in  1  read data beat, in issue order, reads only
iMEM_DATA  in  64  read data
oERR_UNEXPECTED  out  1  sticky: iMEM_VALID with no outstanding read

Behaviour:
- Reset (iRESET high at an edge): all FIFOs empty, counters 0; oDATA_VALID=0, oDATA_DATA=0, oERR_UNEXPECTED=0. Hence oMEM_REQ=0 and oDATA_LOCK=0. Reset mid-operation discards all pending and in-flight requests; the memory side must be reset together with this block.
- Accept: iDATA_REQ && !oDATA_LOCK pushes {ORDER,RW,ADDR,DATA} into the request FIFO. oDATA_LOCK = (req_count == P_REQ_DEPTH), decoded from the registered count. When the FIFO is full and an issue happens in the same cycle, the push is still rejected, because LOCK is already high that cycle.
- Issue:
  - oMEM_REQ = req FIFO non-empty && outstanding_count < P_OUT_DEPTH.
  - Transfer when oMEM_REQ && !iMEM_BUSY. On transfer, pop the req FIFO and push RW into the order queue.
  - oMEM_* are driven combinationally from the FIFO head and are stable while iMEM_BUSY holds.
- Write lane formation (a = ADDR[2:0]):
  - byte: BE = 8'h01<<a; data = DATA[7:0] replicated x8.
  - half: BE = 8'h03<<{a[2:1],0}; data = DATA[15:0] replicated x4.
  - word/3: BE = 8'h0F<<{a[2],00}; data = DATA replicated x2.
  - Misaligned low bits are ignored.
- Read data capture: every iMEM_VALID pushes iMEM_DATA into the read-data FIFO, unless outstanding_reads == 0. In that case the beat is dropped and oERR_UNEXPECTED is set (it stays 1 until reset).
- Response stage (at most one pop per cycle):
  - Head of order queue is a write: pop; next cycle oDATA_VALID=1, oDATA_DATA=0.
  - Head is a read and the read-data FIFO is non-empty: pop both; next cycle oDATA_VALID=1, oDATA_DATA=that beat.
  - Otherwise: oDATA_VALID=0 next cycle. oDATA_DATA holds its last value when VALID=0.
- Ordering: responses strictly in acceptance order; a write ack never overtakes an earlier read.
- Latency:
  - Write accepted at cycle 0, no stall: issued cycle 1, popped cycle 2, oDATA_VALID in cycle 3.
  - Read: if iMEM_VALID arrives in cycle k, oDATA_VALID is in cycle k+2 (earliest).
- Counters: outstanding_count is +1 on issue and -1 on response pop; outstanding_reads is the same, counting reads only. Simultaneous inc/dec leaves the count unchanged. Neither counter can exceed P_OUT_DEPTH, so the read-data FIFO never overflows.
- Throughput: 1 request/cycle sustained when iMEM_BUSY=0 and memory returns 1 beat/cycle.

Test Plan:
- Reset, then one word write: ADDR=0x104, DATA=0xDEADBEEF, cycle 0. Required: oMEM_REQ at cycle 1 with ADDR=0x20, BE=8'hF0, DATA=0xDEADBEEF_DEADBEEF; oDATA_VALID=1, oDATA_DATA=0 at cycle 3.
- Byte write ADDR=0x203, DATA=0x5A -> BE=8'h08, oMEM_DATA=0x5A5A5A5A5A5A5A5A. Half write ADDR=0x206, DATA=0x1234 -> BE=8'hC0.
- Line fill: 8 reads 0x1000..0x1038 offered back-to-back; memory latency 3, iMEM_BUSY=1 for cycles 2-5. Required:
  - LOCK asserts once 4 are queued; all 8 eventually accepted.
  - 8 VALID beats in address order carrying the memory data; no beat lost or duplicated.
- Read 0x40, then write 0x48 accepted the next cycle; memory returns read data 6 cycles after issue. Required: read beat first, write ack the cycle after it, never before.
- Saturation with P_OUT_DEPTH=8: memory never returns data. Required: 8 reads issued, oMEM_REQ drops, req FIFO fills, LOCK=1. Release 8 beats -> 8 responses, then issue resumes.
- iMEM_VALID asserted with no outstanding read -> oERR_UNEXPECTED=1, no oDATA_VALID; it stays 1 until iRESET, and a subsequent iRESET clears it.
